// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between a single-cycle core data port and a
// handshaked data RAM. Stores retire into the FIFO in one cycle and drain to
// memory over mem_req/mem_ack. Loads read RAM combinationally, with
// forwarding from the youngest buffered store to the same word.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   MemWrite/DataAdr/WriteData  core store request, byte address, data
//   ReadData                load data (forwarded or mem_rdata), combinational
//   Stall                   store presented while the FIFO is full
//   Empty                   no stores pending
//   mem_req/mem_addr/mem_wdata/mem_ack  RAM write port (head entry)
//   mem_raddr/mem_rdata     RAM combinational read port
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Empty,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][29:0] addr_q;
    logic [DEPTH-1:0][31:0] data_q;
    logic [AW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [AW:0]            count_q, count_d;
    logic                   full, push, pop;
    logic [AW-1:0]          idx;

    assign full      = (count_q == FULL_CNT);
    assign Empty     = (count_q == '0);
    assign Stall     = MemWrite & full;
    assign push      = MemWrite & ~full;
    assign mem_req   = ~Empty;
    assign pop       = mem_req & mem_ack;
    // Head entry only changes on pop, so the write port is stable until acked.
    assign mem_addr  = {addr_q[head_q], 2'b00};
    assign mem_wdata = data_q[head_q];
    assign mem_raddr = {DataAdr[31:2], 2'b00};

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + AW'(1);
        if (pop)  head_d = head_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= DataAdr[31:2];
            data_q[tail_q] <= WriteData;
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        ReadData = mem_rdata;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (((AW+1)'(i) < count_q) && (addr_q[idx] == DataAdr[31:2]))
                ReadData = data_q[idx];
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ReadData, mem_addr, mem_wdata, mem_raddr;
    logic        Stall, Empty, mem_req;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .Empty(Empty),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference load result: youngest queued store to the word, else RAM.
    function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [31:0] rd);
        ref_rd = rd;
        foreach (q[i]) if (q[i].a == a[31:2]) ref_rd = q[i].d;
    endfunction

    task automatic set_in(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit ack);
        MemWrite  = mw;
        DataAdr   = a;
        WriteData = d;
        mem_ack   = ack;
        mem_rdata = $urandom;
        #1;
    endtask

    // Advance one clock; the model retires/accepts by the FIFO rules.
    task automatic tick();
        bit p, u;
        @(posedge clk);
        p = (q.size() > 0) && mem_ack;
        u = MemWrite && (q.size() < DEPTH);
        if (p) void'(q.pop_front());
        if (u) q.push_back('{a: DataAdr[31:2], d: WriteData});
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        DataAdr = 32'h40;
        mem_rdata = 32'hDEADBEEF;
        #22;
        reset = 1'b0;
        #1;
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", Empty); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", Stall); end
        checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_rd got %h exp deadbeef", ReadData); end
        checks++; if (mem_raddr !== 32'h40) begin errors++; $display("FAIL reset_raddr got %h exp 40", mem_raddr); end
        @(negedge clk);
    endtask

    task automatic test_single_store();
        set_in(1, 32'h64, 32'd7, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_in(0, 32'h0, 32'h0, k == 3);
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL single_req c%0d got %b exp 1", k, mem_req); end
            checks++; if (mem_addr !== 32'h64) begin errors++; $display("FAIL single_addr c%0d got %h exp 64", k, mem_addr); end
            checks++; if (mem_wdata !== 32'd7) begin errors++; $display("FAIL single_data c%0d got %h exp 7", k, mem_wdata); end
            tick();
        end
        set_in(0, 32'h0, 32'h0, 0);
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b exp 1", Empty); end
    endtask

    task automatic test_forwarding();
        set_in(1, 32'h60, 32'd5, 0); tick();
        set_in(1, 32'h60, 32'd9, 0); tick();
        set_in(0, 32'h62, 32'h0, 0);
        checks++; if (ReadData !== 32'd9) begin errors++; $display("FAIL fwd_young got %h exp 9", ReadData); end
        set_in(0, 32'h5C, 32'h0, 0);
        checks++; if (ReadData !== mem_rdata) begin errors++; $display("FAIL fwd_miss got %h exp %h", ReadData, mem_rdata); end
        set_in(0, 32'h60, 32'h0, 1);
        checks++; if (mem_wdata !== 32'd5) begin errors++; $display("FAIL fwd_order0 got %h exp 5", mem_wdata); end
        tick();
        set_in(0, 32'h60, 32'h0, 1);
        checks++; if (mem_wdata !== 32'd9) begin errors++; $display("FAIL fwd_order1 got %h exp 9", mem_wdata); end
        tick();
        set_in(0, 32'h60, 32'h0, 0);
        checks++; if (ReadData !== mem_rdata) begin errors++; $display("FAIL fwd_drained got %h exp %h", ReadData, mem_rdata); end
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL fwd_empty got %b exp 1", Empty); end
    endtask

    task automatic test_full_stall();
        logic [31:0] d;
        logic [31:0] exp_a;
        d = $urandom;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'(4 * i), 32'(100 + i), 0);
            tick();
        end
        set_in(1, 32'h10, d, 0);
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", Stall); end
        tick();
        set_in(1, 32'h10, d, 0);
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL full_hold got %b exp 1", Stall); end
        checks++; if (ReadData !== mem_rdata) begin errors++; $display("FAIL full_notwritten got %h exp %h", ReadData, mem_rdata); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL full_head got %h exp 0", mem_addr); end
        set_in(1, 32'h10, d, 1);
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL full_pop_stall got %b exp 1", Stall); end
        tick();
        set_in(1, 32'h10, d, 0);
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL full_release got %b exp 0", Stall); end
        tick();
        for (int k = 0; k < 4; k++) begin
            set_in(0, 32'h10, 32'h0, 1);
            exp_a = 32'(4 * (k + 1));
            checks++; if (mem_addr !== exp_a) begin errors++; $display("FAIL full_drain_addr k%0d got %h exp %h", k, mem_addr, exp_a); end
            if (k == 3) begin
                checks++; if (mem_wdata !== d) begin errors++; $display("FAIL full_drain_data got %h exp %h", mem_wdata, d); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 10; i++) begin
            set_in(1, 32'(32'h80 + 4 * (i - 1)), 32'(i), 1);
            checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL b2b_stall i%0d got %b exp 0", i, Stall); end
            if (i > 1) begin
                checks++; if (mem_wdata !== 32'(i - 1) || mem_req !== 1'b1) begin
                    errors++; $display("FAIL b2b_data i%0d got %h req %b exp %h", i, mem_wdata, mem_req, i - 1);
                end
            end
            tick();
        end
        set_in(0, 32'h0, 32'h0, 1);
        checks++; if (mem_wdata !== 32'd10) begin errors++; $display("FAIL b2b_last got %h exp a", mem_wdata); end
        tick();
        set_in(0, 32'h0, 32'h0, 0);
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", Empty); end
    endtask

    task automatic test_random();
        logic [31:0] a, exp;
        for (int n = 0; n < 300; n++) begin
            a = 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            set_in(($urandom_range(0, 9) < 6), a, $urandom, ($urandom_range(0, 1) == 1));
            exp = ref_rd(a, mem_rdata);
            checks++; if (ReadData !== exp) begin errors++; $display("FAIL rnd_rd n%0d got %h exp %h", n, ReadData, exp); end
            checks++; if (Stall !== (MemWrite && q.size() == DEPTH)) begin errors++; $display("FAIL rnd_stall n%0d got %b", n, Stall); end
            checks++; if (Empty !== (q.size() == 0) || mem_req !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_empty n%0d got %b req %b exp size %0d", n, Empty, mem_req, q.size());
            end
            if (q.size() != 0) begin
                checks++; if (mem_addr !== {q[0].a, 2'b00} || mem_wdata !== q[0].d) begin
                    errors++; $display("FAIL rnd_head n%0d got %h/%h exp %h/%h", n, mem_addr, mem_wdata, {q[0].a, 2'b00}, q[0].d);
                end
            end
            checks++; if (mem_raddr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL rnd_raddr n%0d got %h", n, mem_raddr); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'(32'h200 + 4 * i), $urandom, 0);
            tick();
        end
        set_in(0, 32'h0, 32'h0, 0);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_pending got %b exp 1", mem_req); end
        #1 reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b exp 0", mem_req); end
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", Empty); end
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        set_in(1, 32'h64, 32'd7, 0);
        tick();
        set_in(0, 32'h0, 32'h0, 1);
        checks++; if (mem_addr !== 32'h64 || mem_wdata !== 32'd7) begin
            errors++; $display("FAIL mid_first got %h/%h exp 64/7", mem_addr, mem_wdata);
        end
        tick();
        set_in(0, 32'h0, 32'h0, 0);
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL mid_drained got %b exp 1", Empty); end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_forwarding();
        test_full_stall();
        test_back_to_back();
        test_random();
        // Drain leftovers from the random phase before the reset scenario.
        for (int n = 0; n < DEPTH + 1; n++) begin
            set_in(0, 32'h0, 32'h0, 1);
            tick();
        end
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle core's data port and a slow, handshaked data RAM. Core stores retire in one cycle into a small FIFO that drains to memory through a req/ack write port. Core loads read memory combinationally, with forwarding from the youngest matching buffered store. The core is stalled only when it issues a store while the FIFO is full.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- MemWrite  input  1  core store request this cycle
- DataAdr  input  32  core byte address for load/store; bits [1:0] ignored (word aligned)
- WriteData  input  32  core store data
- ReadData  output  32  load data to core (combinational)
- Stall  output  1  store cannot be accepted this cycle (combinational)
- Empty  output  1  no stores pending
- mem_req  output  1  write request to RAM
- mem_addr  output  32  write word address (byte address, [1:0]=00)
- mem_wdata  output  32  write data
- mem_ack  input  1  RAM accepted the presented write at this edge
- mem_raddr  output  32  RAM combinational read address (= {DataAdr[31:2],2'b00})
- mem_rdata  input  32  RAM combinational read data

## Operation
- State: DEPTH entries {addr[31:2], data[31:0]}, head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits, range 0..DEPTH).
- Full = (count == DEPTH); Empty = (count == 0).
- Push: MemWrite & ~Full at posedge writes {DataAdr[31:2], WriteData} at tail, tail+1.
- Stall = MemWrite & Full. A stalled store is not written. The core must hold PC and its outputs, then re-present the store.
- Drain: mem_req = ~Empty. mem_addr/mem_wdata present the head entry.
- Pop: mem_req & mem_ack at posedge advances head+1. mem_ack while mem_req=0 is ignored.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full plus pop in the same cycle: Stall is still asserted. No same-cycle pass-through.
- Load forwarding: ReadData = data of the youngest valid entry whose addr equals DataAdr[31:2]. If none matches, ReadData = mem_rdata. The search is from tail-1 back to head; only the count valid entries participate.
- Forwarding is evaluated every cycle regardless of MemWrite; the core decides whether to use it.
- Stores to the same address in order both go to RAM, in order. There is no merging.
- Reset mid-drain: pending stores are discarded and mem_req drops immediately (asynchronously). The RAM must tolerate a withdrawn request.

## Timing
- Reset values: count=0, head=tail=0, Empty=1, mem_req=0, Stall=0 (when MemWrite=0). mem_addr/mem_wdata are don't-care while mem_req=0.
- Store latency: a store pushed at edge N raises mem_req after edge N if the FIFO was empty. It is visible to forwarding after edge N, matching the core's single-cycle load-after-store timing.
- mem_req, mem_addr and mem_wdata are stable from assertion until the edge where mem_ack=1. There are no glitches from push activity.
- RAM acking the same cycle as request: one store retires per cycle. Sustained throughput is 1 store/cycle.
- ReadData, Stall and mem_raddr are purely combinational. There is no registered output on the load path.
- Pointers wrap with no bubble: entry DEPTH-1 is followed by entry 0.

## Test plan
- Reset and idle: assert reset 22 ns and release.
  - Expect Empty=1, mem_req=0, Stall=0.
  - With mem_rdata=32'hDEADBEEF and DataAdr=0x40, expect ReadData=32'hDEADBEEF.
- Single store and drain: MemWrite with addr 0x64, data 7, mem_ack held 0 for 3 cycles then 1.
  - mem_req=1 with mem_addr=0x64, mem_wdata=7, stable for 4 cycles.
  - Empty=1 after the ack edge.
- Forwarding, youngest wins: with mem_ack=0, store 0x60←5 then 0x60←9, then DataAdr=0x62.
  - Expect ReadData=9.
  - DataAdr=0x5C gives mem_rdata.
  - After both drain, 0x60 gives mem_rdata.
- Full and stall: with mem_ack=0, push 4 stores to 0x00,0x04,0x08,0x0C, then MemWrite addr 0x10.
  - Expect Stall=1 and count stays 4.
  - Raise mem_ack for one cycle: 0x00 retires. Stall stays 1 that cycle and drops the next; the 0x10 store is then accepted.
- Wrap and simultaneous push/pop: hold mem_ack=1 and issue 10 back-to-back stores, data 1..10 to 0x80+4i.
  - Expect mem_wdata sequence 1..10 in order.
  - Stall never asserted; Empty=1 one cycle after the last.
- Reset mid-operation: with 3 stores pending, assert reset between clock edges.
  - mem_req falls immediately and Empty=1.
  - After release, the next store to 0x64←7 is the first written.
